apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 10, APB address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles (range 2..255).
REQ-002 Ports SHALL be, one per line; one clock (pclk), reset asynchronous active-low (preset_n):
- pclk  in  1  APB clock; all logic rises on it.
- preset_n  in  1  async active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both high.
- rsp_rdata  out  32  read data (0 for writes/timeouts).
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_WIDTH  APB address.
- psel1  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB strobes.
- pready  in  1  completer ready.
- prdata  in  32  completer read data.
- pslverr  in  1  completer error.

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all APB outputs registered.
REQ-004 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE ignored, nothing queued.
REQ-005 IDLE with cmd_valid=1: latch cmd_*; drive paddr/pwrite/pwdata/pstrb; psel1=1, penable=0; go SETUP.
REQ-006 Reads SHALL drive pstrb=4'b0000 and pwdata=0 regardless of cmd_strb/cmd_wdata.
REQ-007 SETUP: penable=1, go ACCESS after exactly one cycle; paddr/pwrite/pwdata/pstrb stable from SETUP through end of ACCESS.
REQ-008 ACCESS with pready=1: capture prdata (reads; 0 for writes) into rsp_rdata, pslverr into rsp_err, rsp_timeout=0; psel1=0, penable=0, rsp_valid=1; go RESP.
REQ-009 ACCESS wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready=0; pready=0 on the TIMEOUT_CYCLES-th consecutive ACCESS cycle: abort, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel1=penable=0, go RESP.
REQ-010 pready=1 on the same cycle the counter would expire SHALL win (normal completion).
REQ-011 RESP: hold rsp_valid and rsp_* stable until rsp_ready=1, then rsp_valid=0 and go IDLE; rsp_ready high on first RESP cycle gives one-cycle rsp_valid.
REQ-012 Minimum latency: acceptance cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 (pready=1 at first ACCESS); back-to-back command period minimum 4 cycles.
REQ-013 pslverr SHALL be ignored when pready=0; prdata ignored outside ACCESS.

Reset
REQ-014 preset_n low SHALL asynchronously force IDLE, all outputs 0 (cmd_ready=0 during reset, 1 on first cycle after release), counter 0, latched command discarded; mid-transfer reset drops psel1/penable immediately and produces no response.

Structure
REQ-015 Shared package apb_pkg SHALL hold ADDR_WIDTH, DATA_REG_ADDR=5, CONFIG_REG_ADDR=6, STATUS_REG_ADDR=7, and the FSM state enum.
REQ-016 Wait counter with expire flag SHALL be one sub-module apb_timeout_cnt (clear, enable, expire output, TIMEOUT_CYCLES parameter).

Verification
REQ-017 Write addr 5, wdata 32'hA5A5_1234, strb 4'b0101, pready=1 -> psel1 N+1..N+2, penable N+2 only, pstrb 4'b0101, rsp_valid N+3, rsp_err=0.
REQ-018 Read addr 6, pready low 3 ACCESS cycles then high with prdata 32'h0000_00C3 -> pstrb=0, rsp_rdata 32'h0000_00C3 at N+6.
REQ-019 Write with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-020 pready held 0 -> after 16 ACCESS cycles rsp_err=1, rsp_timeout=1, psel1=0; pready=1 on 16th cycle -> normal response.
REQ-021 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, new cmd_valid ignored; then accepted.
REQ-022 preset_n low during ACCESS -> psel1/penable/rsp_valid 0 same cycle; after release cmd_ready=1, no stale response.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants and FSM state encoding for the APB command master.
package apb_pkg;

  localparam int ADDR_WIDTH = 10;

  localparam logic [ADDR_WIDTH-1:0] DATA_REG_ADDR   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] CONFIG_REG_ADDR = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] STATUS_REG_ADDR = ADDR_WIDTH'(7);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expire_o flags the TIMEOUT_CYCLES-th consecutive wait cycle.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expire_o = enable_i && (cnt_q == LAST_WAIT);

  // NOTE: cnt_d gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Converts a valid/ready command into one APB transfer and returns a held response.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel1,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [31:0]           prdata,
  input  logic                  pslverr
);

  apb_state_e            state_q;
  logic                  cmd_ready_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [31:0]           pwdata_q;
  logic [3:0]            pstrb_q;
  logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [31:0]           rsp_rdata_q;

  logic accept;
  logic wait_cycle;
  logic tmo_expire;

  // cmd_ready_q is only ever set while in IDLE, so it alone qualifies acceptance.
  assign accept     = cmd_valid && cmd_ready_q;
  assign wait_cycle = (state_q == ACCESS) && !pready;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (pclk),
    .rst_n   (preset_n),
    .clear_i (accept),
    .enable_i(wait_cycle),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            paddr_q     <= cmd_addr;
            pwrite_q    <= cmd_write;
            pwdata_q    <= cmd_write ? cmd_wdata : '0;
            pstrb_q     <= cmd_write ? cmd_strb : '0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A completing pready takes priority over an expiring wait counter.
          if (pready) begin
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (tmo_expire) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign paddr       = paddr_q;
  assign psel1       = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
